// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S types and defaults for the I2S transmit and receive blocks
package i2s_pkg;
  localparam int WIDTH_DEFAULT = 16;
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] left;
    logic [WIDTH_DEFAULT-1:0] right;
  } i2s_pair_t;
  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} chan_e;
endpackage

// File: rtl/i2s_piso.sv
// i2s_piso: MSB-first load/shift register with saturating bit counter; zero fill once the word is out
module i2s_piso #(
  parameter int WIDTH = 16
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             sdata
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    cnt;
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      shift <= '0;
      cnt   <= '0;
      sdata <= 1'b0;
    end else if (load) begin
      sdata <= data[WIDTH-1];
      shift <= data << 1;
      cnt   <= CW'(1);
    end else if (cnt < CW'(WIDTH)) begin
      sdata <= shift[WIDTH-1];
      shift <= shift << 1;
      cnt   <= cnt + CW'(1);
    end else begin
      sdata <= 1'b0;
    end
endmodule

// File: rtl/i2s_slave_tx.sv
// i2s_slave_tx: slave-mode I2S transmitter; ws comes from the master, stereo pairs are
// double-buffered (pending + active) and serialised MSB first, left on ws=0, right on ws=1
module i2s_slave_tx import i2s_pkg::*; #(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             ws,
  input  logic [WIDTH-1:0] left_i,
  input  logic [WIDTH-1:0] right_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             sdata,
  output logic             underrun_o
);
  logic             ws_q, synced, pend_v, fall, rise, accept, load;
  logic [WIDTH-1:0] pend_l, pend_r, act_r, nxt_l, nxt_r, shift_in;
  // Active left goes straight into the shifter at the fall, so only active right is stored
  always_comb begin
    fall     = ws_q & ~ws;
    rise     = ~ws_q & ws & synced;
    ready_o  = ~pend_v | fall;
    accept   = valid_i & ready_o;
    nxt_l    = pend_v ? pend_l : '0;
    nxt_r    = pend_v ? pend_r : '0;
    load     = fall | rise;
    shift_in = (chan_e'(ws) == LEFT) ? nxt_l : act_r;
  end
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      ws_q       <= 1'b0;
      synced     <= 1'b0;
      pend_v     <= 1'b0;
      pend_l     <= '0;
      pend_r     <= '0;
      act_r      <= '0;
      underrun_o <= 1'b0;
    end else begin
      ws_q       <= ws;
      underrun_o <= fall & ~pend_v;
      pend_v     <= accept | (pend_v & ~fall);
      if (fall) begin
        synced <= 1'b1;
        act_r  <= nxt_r;
      end
      if (accept) begin
        pend_l <= left_i;
        pend_r <= right_i;
      end
    end
  i2s_piso #(.WIDTH(WIDTH)) u_piso (
    .sclk  (sclk),
    .rst_n (rst_n),
    .load  (load),
    .data  (shift_in),
    .sdata (sdata)
  );
endmodule

// File: tb/tb_i2s_slave_tx.sv
// tb_i2s_slave_tx: bench acts as I2S master (ws on falling sclk) and receiver (sdata captured per channel);
// accepted pairs go into a scoreboard queue and are popped at each left-frame start
module tb_i2s_slave_tx;
  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;
  typedef struct {
    bit          has;
    logic [15:0] l;
    logic [15:0] r;
    int          n;
    int          ur;
  } vec_t;

  logic        sclk = 1'b0;
  logic        rst_n, ws, valid_i, ready_o, sdata, underrun_o;
  logic [15:0] left_i, right_i;
  int          n_chk = 0;
  int          n_fail = 0;
  pair_t       send_q[$];
  pair_t       exp_q[$];
  vec_t        tbl[7];

  i2s_slave_tx #(.WIDTH(16)) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .ws         (ws),
    .left_i     (left_i),
    .right_i    (right_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sdata      (sdata),
    .underrun_o (underrun_o)
  );

  always #5 sclk = ~sclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Source side: holds valid with the head of send_q until ready, pushes to the scoreboard on acceptance
  initial begin
    valid_i = 1'b0;
    left_i  = '0;
    right_i = '0;
    forever begin
      @(negedge sclk);
      #1;
      if (send_q.size() > 0) begin
        valid_i = 1'b1;
        left_i  = send_q[0].l;
        right_i = send_q[0].r;
        #1;
        if (ready_o) exp_q.push_back(send_q.pop_front());
      end else begin
        valid_i = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] trunc(input logic [15:0] d, input int n);
    logic [31:0] w;
    w = {16'h0, d};
    return (n <= 16) ? (w >> (16 - n)) : (w << (n - 16));
  endfunction

  // Must be called at a falling sclk edge; returns the last 32 captured bits and underrun pulses
  task automatic chan(input logic w, input int n, output logic [31:0] cap, output int ur);
    ws  = w;
    cap = '0;
    ur  = 0;
    repeat (n) begin
      @(posedge sclk);
      #1;
      ur += int'(underrun_o);
      @(negedge sclk);
      cap = {cap[30:0], sdata};
    end
  endtask

  task automatic frame(input int n, input int exp_ur);
    pair_t       e;
    logic [31:0] cl, cr;
    int          u1, u2;
    @(negedge sclk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chan(1'b0, n, cl, u1);
    chan(1'b1, n, cr, u2);
    check("left_word", cl, trunc(e.l, n));
    check("right_word", cr, trunc(e.r, n));
    check("underrun_count", u1 + u2, exp_ur);
  endtask

  task automatic wait_sent();
    int i;
    i = 0;
    while (send_q.size() > 0 && i < 200) begin
      @(negedge sclk);
      i++;
    end
    check("accept_timeout", send_q.size(), 0);
  endtask

  initial begin
    logic [31:0] cl, cr;
    int          u;
    int          i;
    tbl[0] = '{1'b1, 16'hdead, 16'hbeef, 16, 0};
    tbl[1] = '{1'b0, 16'h0000, 16'h0000, 16, 1};
    tbl[2] = '{1'b0, 16'h0000, 16'h0000, 16, 1};
    tbl[3] = '{1'b1, 16'ha5a5, 16'h5a5a, 24, 0};
    tbl[4] = '{1'b1, 16'hffff, 16'h0000, 8, 0};
    tbl[5] = '{1'b1, 16'hc3c3, 16'h3c3c, 8, 0};
    tbl[6] = '{1'b1, 16'h1234, 16'h5678, 16, 0};
    rst_n = 1'b0;
    ws    = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    check("reset_sdata", sdata, 1'b0);
    check("reset_ready", ready_o, 1'b1);
    check("reset_underrun", underrun_o, 1'b0);
    @(negedge sclk);
    rst_n = 1'b1;
    repeat (4) @(negedge sclk);
    check("idle_sdata", sdata, 1'b0);

    foreach (tbl[k]) begin
      if (tbl[k].has) begin
        send_q.push_back('{tbl[k].l, tbl[k].r});
        wait_sent();
      end
      frame(tbl[k].n, tbl[k].ur);
    end

    // Stream with valid held: second pair waits while pending is full, order preserved
    send_q.push_back('{16'h0001, 16'h8001});
    send_q.push_back('{16'h0002, 16'h8002});
    send_q.push_back('{16'h0003, 16'h8003});
    i = 0;
    while (exp_q.size() == 0 && i < 200) begin
      @(negedge sclk);
      i++;
    end
    repeat (3) @(negedge sclk);
    #3;
    check("ready_low_full", ready_o, 1'b0);
    check("valid_held", valid_i, 1'b1);
    frame(16, 0);
    frame(16, 0);
    frame(16, 0);
    frame(16, 1);

    // ws stuck high: word already finished, sdata stays 0, pending held, ready low
    send_q.push_back('{16'h7777, 16'h8888});
    send_q.push_back('{16'h9999, 16'haaaa});
    i = 0;
    while (exp_q.size() == 0 && i < 200) begin
      @(negedge sclk);
      i++;
    end
    @(negedge sclk);
    chan(1'b1, 40, cr, u);
    check("stuck_sdata", cr, 32'h0);
    check("stuck_underrun", u, 0);
    #3;
    check("stuck_ready", ready_o, 1'b0);
    frame(16, 0);
    frame(16, 0);

    // Reset in the middle of a right channel
    send_q.push_back('{16'h1357, 16'hffff});
    wait_sent();
    @(negedge sclk);
    chan(1'b0, 16, cl, u);
    check("pre_reset_left", cl, 32'h1357);
    chan(1'b1, 6, cr, u);
    check("pre_reset_right", cr, 32'h3f);
    rst_n = 1'b0;
    #1;
    check("mid_reset_sdata", sdata, 1'b0);
    check("mid_reset_ready", ready_o, 1'b1);
    check("mid_reset_underrun", underrun_o, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    chan(1'b1, 10, cr, u);
    check("post_reset_quiet", cr, 32'h0);
    check("post_reset_no_underrun", u, 0);
    frame(16, 1);
    send_q.push_back('{16'h4242, 16'h2424});
    wait_sent();
    frame(16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
